complex_alu_arbiter: RTL and testbench
======================================

Name: complex_alu_arbiter

Overview:
- Shares one complex-number ALU between two requesters: requester 0 and requester 1.
- Operands are 64-bit complex values: [63:32] real, [31:0] imaginary.
- For each request, the block arbitrates round-robin, validates the 4-bit opcode, and issues a one-cycle start to the ALU.
- It then waits for the ALU done with a bounded timeout, and returns the registered result with a status code to the granted requester.

Parameters:
- DATA_W, 64, operand/result width.
- OPR_W, 4, opcode width.
- TIMEOUT, 255, maximum WAIT cycles before a timeout response (1..2^CNT_W-1).
- CNT_W, 8, width of the timeout counter.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  request from requester 0; level, held until rsp_valid0.
- opr0  in  OPR_W  opcode from requester 0.
- a0  in  DATA_W  operand A from requester 0.
- b0  in  DATA_W  operand B from requester 0.
- req1  in  1  request from requester 1; same rules as req0.
- opr1  in  OPR_W  opcode from requester 1.
- a1  in  DATA_W  operand A from requester 1.
- b1  in  DATA_W  operand B from requester 1.
- gnt0  out  1  one-cycle pulse: request 0 accepted.
- gnt1  out  1  one-cycle pulse: request 1 accepted.
- rsp_valid0  out  1  one-cycle pulse: response for requester 0.
- rsp_valid1  out  1  one-cycle pulse: response for requester 1.
- rsp_err  out  2  status: 00 ok, 01 illegal opcode, 10 timeout; valid with rsp_valid*.
- rsp_data  out  DATA_W  result; valid with rsp_valid*.
- busy  out  1  high whenever state != IDLE.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_opr  out  OPR_W  latched opcode to the ALU.
- alu_a  out  DATA_W  latched operand A to the ALU.
- alu_b  out  DATA_W  latched operand B to the ALU.
- alu_done  in  1  ALU result ready; sampled only in WAIT.
- alu_out  in  DATA_W  ALU result.

Behaviour:
- Reset (async):
  - state=IDLE, last=1 (so requester 0 wins the first contention).
  - All outputs 0, including alu_opr/a/b, rsp_data and rsp_err.
  - Timeout counter cnt=0, internal owner=0.
- All outputs are registered.
- Legal opcodes: 0000, 0001, 0010, 0011, 0100, 0110, 1000, 1001, 1010. Every other value is illegal.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE:
    - Only req0 → owner=0. Only req1 → owner=1. Both → owner=~last.
    - On acceptance, latch opr/a/b of the owner into alu_opr/alu_a/alu_b and pulse gnt<owner> (visible next cycle).
    - Legal opcode → ISSUE. Illegal opcode → RESP with rsp_err=01, rsp_data=0, no ALU start.
    - No request → stay in IDLE.
  - ISSUE: alu_start=1 for exactly this cycle; cnt<=0; → WAIT.
  - WAIT:
    - alu_done=1 → rsp_data<=alu_out, rsp_err<=00, → RESP.
    - Else if cnt==TIMEOUT-1 → rsp_data<=0, rsp_err<=10, → RESP.
    - Else cnt<=cnt+1.
    - alu_done wins if it arrives in the same cycle as the timeout.
  - RESP:
    - rsp_valid<owner>=1 for one cycle; last<=owner; → IDLE.
    - rsp_data/rsp_err hold their value until the next response.
- Latency, req sampled in IDLE at cycle N:
  - gnt at N+1.
  - alu_start at N+1.
  - Earliest alu_done sample at N+2.
  - rsp_valid at N+3.
  - Illegal opcode: rsp_valid at N+2.
- The requester must drop req in the cycle after rsp_valid; a req still high in IDLE is treated as a new request.
- Requests are sampled only in IDLE. Changes to the other requester's inputs while busy have no effect.
- alu_done outside WAIT is ignored, including a late done after a timeout.
- alu_opr/a/b remain stable from ISSUE through RESP.
- Reset mid-operation: immediate return to IDLE; any pending response is dropped; alu_start deasserts asynchronously.

Test Plan:
- req0, opr0=0010, a0=0x00000003_00000004, b0=0x00000001_00000002; alu_done after 2 WAIT cycles with alu_out=0x00000004_00000006 → gnt0 at +1, single alu_start, rsp_valid0 at +5, rsp_err=00, rsp_data=0x00000004_00000006.
- req0 and req1 both asserted at cycle 0 after reset, both held until their response → requester 0 served first, then requester 1; repeat with both asserted again → requester 0 served first again; then a lone req1 followed by both → requester 0 wins (last=1).
- req1, opr1=0101 → no alu_start, rsp_valid1 2 cycles after the IDLE sample, rsp_err=01, rsp_data=0.
- TIMEOUT=4, alu_done never asserted → rsp_valid at cycle N+6 with rsp_err=10; a later alu_done pulse in IDLE produces no response.
- alu_done in the same cycle as cnt==TIMEOUT-1 → rsp_err=00, rsp_data=alu_out.
- Reset asserted during WAIT → busy=0, all outputs 0 immediately, no rsp_valid; after release, the next req0 is served normally.

Source files
------------

// File: rtl/complex_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : complex_alu_arbiter
// Purpose  : Round-robin arbiter that shares one complex-number ALU between
//            two requesters. Validates the opcode, issues a one-cycle start,
//            waits for done with a bounded timeout and returns a registered
//            result plus status code to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module complex_alu_arbiter #(
  parameter int DATA_W  = 64,
  parameter int OPR_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic [OPR_W-1:0]  opr0_i,
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] b0_i,
  input  logic              req1_i,
  input  logic [OPR_W-1:0]  opr1_i,
  input  logic [DATA_W-1:0] a1_i,
  input  logic [DATA_W-1:0] b1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rsp_valid0_o,
  output logic              rsp_valid1_o,
  output logic [1:0]        rsp_err_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              alu_start_o,
  output logic [OPR_W-1:0]  alu_opr_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic              alu_done_i,
  input  logic [DATA_W-1:0] alu_out_i
);

  // One bit per opcode value: 0,1,2,3,4,6,8,9,10 are legal.
  localparam logic [(2**OPR_W)-1:0] LEGAL_MASK = (2**OPR_W)'(16'h075F);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic               owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               gnt0_q;
  logic               gnt1_q;
  logic               rsp_valid0_q;
  logic               rsp_valid1_q;
  logic [1:0]         rsp_err_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               busy_q;
  logic               alu_start_q;
  logic [OPR_W-1:0]   alu_opr_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;

  logic               owner_d;
  logic [OPR_W-1:0]   opr_d;
  logic [DATA_W-1:0]  a_d;
  logic [DATA_W-1:0]  b_d;
  logic               legal_d;

  // Round-robin pick of the candidate owner and its operand/opcode mux.
  always_comb begin
    owner_d = 1'b0;
    if (req0_i && req1_i) begin
      owner_d = ~last_q;
    end else if (req1_i) begin
      owner_d = 1'b1;
    end
    opr_d   = owner_d ? opr1_i : opr0_i;
    a_d     = owner_d ? a1_i   : a0_i;
    b_d     = owner_d ? b1_i   : b0_i;
    legal_d = LEGAL_MASK[opr_d];
  end

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_err_q    <= ERR_OK;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_opr_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      alu_start_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            owner_q   <= owner_d;
            gnt0_q    <= ~owner_d;
            gnt1_q    <= owner_d;
            alu_opr_q <= opr_d;
            alu_a_q   <= a_d;
            alu_b_q   <= b_d;
            busy_q    <= 1'b1;
            if (legal_d) begin
              state_q     <= ISSUE;
              alu_start_q <= 1'b1;
            end else begin
              // Illegal opcode: skip the ALU, the response follows from RESP.
              state_q    <= RESP;
              rsp_err_q  <= ERR_ILLEGAL;
              rsp_data_q <= '0;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (alu_done_i) begin
            rsp_data_q   <= alu_out_i;
            rsp_err_q    <= ERR_OK;
            rsp_valid0_q <= ~owner_q;
            rsp_valid1_q <= owner_q;
            state_q      <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= ERR_TIMEOUT;
            rsp_valid0_q <= ~owner_q;
            rsp_valid1_q <= owner_q;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          // Entered from WAIT the pulse is already up; entered from IDLE
          // (illegal opcode) it is raised here and RESP lasts one more cycle.
          if (rsp_valid0_q || rsp_valid1_q) begin
            last_q  <= owner_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rsp_valid0_q <= ~owner_q;
            rsp_valid1_q <= owner_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0_o       = gnt0_q;
  assign gnt1_o       = gnt1_q;
  assign rsp_valid0_o = rsp_valid0_q;
  assign rsp_valid1_o = rsp_valid1_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = busy_q;
  assign alu_start_o  = alu_start_q;
  assign alu_opr_o    = alu_opr_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_alu_arbiter
// Purpose  : Table-driven bench for complex_alu_arbiter (TIMEOUT=4), plus
//            hand-written arbitration, late-done and mid-operation reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  opr0 = '0, opr1 = '0;
  logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        alu_done = 1'b0;
  logic [63:0] alu_out = '0;

  logic        gnt0, gnt1, rsp_valid0, rsp_valid1, busy, alu_start;
  logic [1:0]  rsp_err;
  logic [63:0] rsp_data, alu_a, alu_b;
  logic [3:0]  alu_opr;

  int n_app = 0;
  int n_mis = 0;

  typedef struct {
    int          who;
    logic [3:0]  opr;
    logic [63:0] a;
    logic [63:0] b;
    int          done_at;   // cycle N+k in which alu_done is high, -1 never
    logic [63:0] out;
    logic [1:0]  err;
    logic [63:0] data;
    int          lat;       // cycles from IDLE sample to rsp_valid
    int          starts;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  complex_alu_arbiter #(
    .DATA_W (64),
    .OPR_W  (4),
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req0_i      (req0),
    .opr0_i      (opr0),
    .a0_i        (a0),
    .b0_i        (b0),
    .req1_i      (req1),
    .opr1_i      (opr1),
    .a1_i        (a1),
    .b1_i        (b1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rsp_valid0_o(rsp_valid0),
    .rsp_valid1_o(rsp_valid1),
    .rsp_err_o   (rsp_err),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .alu_start_o (alu_start),
    .alu_opr_o   (alu_opr),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_done_i  (alu_done),
    .alu_out_i   (alu_out)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_app++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from v.who; the bench plays the ALU per v.done_at.
  task automatic run_txn(input vec_t v);
    int   starts;
    int   lat;
    logic rv_own, rv_oth;
    starts = 0;
    lat    = -1;
    rv_oth = 1'b0;
    if (v.who == 0) begin
      req0 = 1'b1; opr0 = v.opr; a0 = v.a; b0 = v.b;
    end else begin
      req1 = 1'b1; opr1 = v.opr; a1 = v.a; b1 = v.b;
    end
    alu_done = 1'b0;
    alu_out  = v.out;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        chk("gnt_own",  64'(v.who == 0 ? gnt0 : gnt1), 64'd1);
        chk("gnt_oth",  64'(v.who == 0 ? gnt1 : gnt0), 64'd0);
        chk("alu_opr",  64'(alu_opr), 64'(v.opr));
        chk("alu_b",    alu_b, v.b);
      end
      // Idle requester's operands wander; they must not matter.
      if (v.who == 0) begin
        a1 = {$urandom, $urandom}; opr1 = 4'($urandom);
      end else begin
        a0 = {$urandom, $urandom}; opr0 = 4'($urandom);
      end
      if (alu_start) starts++;
      rv_own = (v.who == 0) ? rsp_valid0 : rsp_valid1;
      if ((v.who == 0 ? rsp_valid1 : rsp_valid0)) rv_oth = 1'b1;
      if (rv_own) begin
        lat = k;
        break;
      end
      alu_done = (k == v.done_at);
    end
    chk("latency",   64'(lat), 64'(v.lat));
    chk("rsp_err",   64'(rsp_err), 64'(v.err));
    chk("rsp_data",  rsp_data, v.data);
    chk("starts",    64'(starts), 64'(v.starts));
    chk("rv_other",  64'(rv_oth), 64'd0);
    chk("alu_a_hold", alu_a, v.a);
    if (v.who == 0) req0 = 1'b0; else req1 = 1'b0;
    alu_done = 1'b0;
    step();
    chk("busy_after", 64'(busy), 64'd0);
    chk("rv_pulse",   64'(rsp_valid0 | rsp_valid1), 64'd0);
  endtask

  // Both requesters raise req together; record grant order.
  task automatic serve_both(output int first, output int second);
    int ng, nresp;
    logic pend;
    ng = 0; nresp = 0; pend = 1'b0;
    first = -1; second = -1;
    req0 = 1'b1; opr0 = 4'b0001; a0 = 64'h11; b0 = 64'h22;
    req1 = 1'b1; opr1 = 4'b0011; a1 = 64'h33; b1 = 64'h44;
    alu_out = 64'h0000_0005_0000_0007;
    for (int k = 0; k < 60 && nresp < 2; k++) begin
      step();
      alu_done = 1'b0;
      if (pend) begin alu_done = 1'b1; pend = 1'b0; end
      if (alu_start) pend = 1'b1;
      if (gnt0) begin if (ng == 0) first = 0; else second = 0; ng++; end
      if (gnt1) begin if (ng == 0) first = 1; else second = 1; ng++; end
      if (rsp_valid0) begin req0 = 1'b0; nresp++; end
      if (rsp_valid1) begin req1 = 1'b0; nresp++; end
    end
    alu_done = 1'b0;
    chk("both_served", 64'(nresp), 64'd2);
    step();
  endtask

  // A done pulse with nobody in WAIT must not produce a response.
  task automatic late_done();
    logic seen;
    seen = 1'b0;
    alu_done = 1'b1;
    alu_out  = 64'hFFFF_0000_FFFF_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rsp_valid0 || rsp_valid1 || busy || alu_start) seen = 1'b1;
    end
    alu_done = 1'b0;
    chk("late_done_ignored", 64'(seen), 64'd0);
  endtask

  initial begin
    int f, s;
    logic seen;
    vecs[0]  = '{0, 4'b0010, 64'h00000003_00000004, 64'h00000001_00000002, 4,
                 64'h00000004_00000006, 2'b00, 64'h00000004_00000006, 5, 1};
    vecs[1]  = '{0, 4'b0000, 64'h1, 64'h2, 2,
                 64'hDEAD_BEEF_0000_0001, 2'b00, 64'hDEAD_BEEF_0000_0001, 3, 1};
    vecs[2]  = '{1, 4'b1010, 64'h5, 64'h6, 3,
                 64'h1234_5678_9ABC_DEF0, 2'b00, 64'h1234_5678_9ABC_DEF0, 4, 1};
    vecs[3]  = '{1, 4'b0101, 64'h7, 64'h8, -1, 64'h0, 2'b01, 64'h0, 2, 0};
    vecs[4]  = '{0, 4'b1111, 64'h9, 64'hA, -1, 64'h0, 2'b01, 64'h0, 2, 0};
    vecs[5]  = '{0, 4'b0111, 64'hB, 64'hC, -1, 64'h0, 2'b01, 64'h0, 2, 0};
    vecs[6]  = '{1, 4'b0110, 64'hD, 64'hE, 2,
                 64'hA5A5_5A5A_0F0F_F0F0, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0, 3, 1};
    vecs[7]  = '{0, 4'b1001, 64'hF, 64'h10, -1, 64'h0, 2'b10, 64'h0, 6, 1};
    vecs[8]  = '{1, 4'b0100, 64'h12, 64'h13, 5,
                 64'hCAFE_0000_0000_BABE, 2'b00, 64'hCAFE_0000_0000_BABE, 6, 1};
    vecs[9]  = '{0, 4'b1011, 64'h14, 64'h15, -1, 64'h0, 2'b01, 64'h0, 2, 0};
    vecs[10] = '{1, 4'b0011, 64'h16, 64'h17, 3,
                 64'h0000_0001_0000_0002, 2'b00, 64'h0000_0001_0000_0002, 4, 1};
    vecs[11] = '{0, 4'b1000, 64'h18, 64'h19, 2,
                 64'h7777_8888_9999_AAAA, 2'b00, 64'h7777_8888_9999_AAAA, 3, 1};

    // Reset state
    step();
    step();
    chk("rst_gnt",   64'({gnt0, gnt1}), 64'd0);
    chk("rst_rv",    64'({rsp_valid0, rsp_valid1}), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_start", 64'(alu_start), 64'd0);
    chk("rst_opr",   64'(alu_opr), 64'd0);
    chk("rst_ab",    alu_a | alu_b, 64'd0);
    chk("rst_data",  rsp_data, 64'd0);
    chk("rst_err",   64'(rsp_err), 64'd0);
    rst = 1'b0;
    step();

    // Round-robin: both -> 0 then 1, again both -> 0 then 1
    serve_both(f, s);
    chk("rr1_first", 64'(f), 64'd0);
    chk("rr1_second", 64'(s), 64'd1);
    serve_both(f, s);
    chk("rr2_first", 64'(f), 64'd0);
    chk("rr2_second", 64'(s), 64'd1);
    // Lone req1 then both -> requester 0 wins
    run_txn(vecs[2]);
    serve_both(f, s);
    chk("rr3_first", 64'(f), 64'd0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i]);
      if (vecs[i].err == 2'b10) late_done();
    end

    // Reset in the middle of WAIT
    req0 = 1'b1; opr0 = 4'b0001; a0 = 64'h55; b0 = 64'h66; alu_done = 1'b0;
    step();   // ISSUE
    step();   // WAIT
    step();   // WAIT
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_start", 64'(alu_start), 64'd0);
    chk("mid_rst_alu",   {60'd0, alu_opr} | alu_a | alu_b, 64'd0);
    chk("mid_rst_rsp",   rsp_data | 64'(rsp_err), 64'd0);
    req0 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) rst = 1'b0;
      if (rsp_valid0 || rsp_valid1) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", 64'(seen), 64'd0);
    run_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
